// File: rtl/cpu19_pkg.sv
// rtl/cpu19_pkg.sv - shared opcode, state and ALU control encodings for the cpu19 core
package cpu19_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_ADD      = 5'b00000;
  localparam opcode_t OP_IMM_A    = 5'b00100;
  localparam opcode_t OP_IMM_B    = 5'b00101;
  localparam opcode_t OP_ALU_LAST = 5'b01001;
  localparam opcode_t OP_JMP      = 5'b01010;
  localparam opcode_t OP_BEQ      = 5'b01011;
  localparam opcode_t OP_BNE      = 5'b01100;
  localparam opcode_t OP_LD       = 5'b01111;
  localparam opcode_t OP_ST       = 5'b10000;
  localparam opcode_t OP_HLT      = 5'b11111;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  // BNE reuses the BEQ compare; only the branch condition is inverted
  localparam logic [4:0] ALU_CMP  = 5'b01011;

  function automatic logic is_alu_op(input opcode_t op);
    return op <= OP_ALU_LAST;
  endfunction

  function automatic logic is_exec_op(input opcode_t op);
    return is_alu_op(op) || (op inside {OP_JMP, OP_BEQ, OP_BNE, OP_LD, OP_ST});
  endfunction

  function automatic logic uses_sbsc(input opcode_t op);
    return op inside {OP_IMM_A, OP_IMM_B, OP_ST, OP_BEQ, OP_BNE, OP_JMP};
  endfunction

  function automatic logic [4:0] alu_code(input opcode_t op);
    return (op == OP_BNE) ? ALU_CMP : op;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts data-memory wait cycles and flags a timeout
module mem_wait_timer #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] r_count;

  // Expiry is seen during the MAX-th waiting cycle so the FSM leaves MEM on that edge
  assign o_expired = i_enable && (r_count == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM for the cpu19 datapath
module multicycle_ctrl
  import cpu19_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int RETIRE_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [18:0]         instr,
  input  logic [3:0]          flag,
  input  logic                mem_ready,
  output logic                IRWE,
  output logic                PCWE,
  output logic                PCSrc,
  output logic                JMP,
  output logic                RegC,
  output logic                SBSC,
  output logic                RegWE,
  output logic                MemWE,
  output logic                MemRE,
  output logic                DLDM,
  output logic [4:0]          ALUcontrol,
  output logic [2:0]          state,
  output logic                error,
  output logic [RETIRE_W-1:0] retired
);

  state_t              r_state;
  opcode_t             r_opcode;
  logic [1:0]          r_rst_sync;
  logic                r_run_d;
  logic                r_irwe, r_pcwe, r_pcsrc, r_jmp, r_regc, r_sbsc;
  logic                r_regwe, r_memwe, r_memre, r_dldm;
  logic [4:0]          r_alu;
  logic                r_error;
  logic [RETIRE_W-1:0] r_retired;

  logic w_timer_clear, w_timer_en, w_expired;
  logic w_unused;

  assign w_timer_clear = (r_state != S_MEM);
  assign w_timer_en    = (r_state == S_MEM) && !mem_ready;
  assign w_unused      = ^{instr[13:0], flag[2:0]};

  mem_wait_timer #(.MAX(MEM_WAIT_MAX)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  // Outputs are registered with the state: each branch sets what the next state drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_opcode  <= '0;
      r_run_d   <= 1'b0;
      r_irwe    <= 1'b0;
      r_pcwe    <= 1'b0;
      r_pcsrc   <= 1'b0;
      r_jmp     <= 1'b0;
      r_regc    <= 1'b0;
      r_sbsc    <= 1'b0;
      r_regwe   <= 1'b0;
      r_memwe   <= 1'b0;
      r_memre   <= 1'b0;
      r_dldm    <= 1'b0;
      r_alu     <= ALU_NONE;
      r_error   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_run_d <= run;
      r_irwe  <= 1'b0;
      r_pcwe  <= 1'b0;
      r_pcsrc <= 1'b0;
      r_jmp   <= 1'b0;
      r_regc  <= 1'b0;
      r_sbsc  <= 1'b0;
      r_regwe <= 1'b0;
      r_memwe <= 1'b0;
      r_memre <= 1'b0;
      r_dldm  <= 1'b0;
      r_alu   <= ALU_NONE;

      case (r_state)
        S_IDLE: begin
          if (run && r_rst_sync[1]) begin
            r_state <= S_FETCH;
            r_irwe  <= 1'b1;
            r_pcwe  <= 1'b1;
          end
        end

        S_FETCH: begin
          r_opcode <= instr[18:14];
          r_state  <= S_DECODE;
        end

        S_DECODE: begin
          if (is_exec_op(r_opcode)) begin
            r_state <= S_EXEC;
            r_alu   <= alu_code(r_opcode);
            r_sbsc  <= uses_sbsc(r_opcode);
            r_regc  <= (r_opcode == OP_IMM_A) || (r_opcode == OP_IMM_B);
            r_dldm  <= (r_opcode == OP_LD) || (r_opcode == OP_ST);
            case (r_opcode)
              OP_BEQ: begin
                r_pcwe  <= flag[3];
                r_pcsrc <= flag[3];
              end
              OP_BNE: begin
                r_pcwe  <= !flag[3];
                r_pcsrc <= !flag[3];
              end
              OP_JMP: begin
                r_pcwe  <= 1'b1;
                r_pcsrc <= 1'b1;
                r_jmp   <= 1'b1;
              end
              default: ;
            endcase
          end else if (r_opcode == OP_HLT) begin
            r_state   <= S_HALT;
            r_retired <= r_retired + 1'b1;
          end else begin
            r_error <= 1'b1;
            r_state <= S_HALT;
          end
        end

        S_EXEC: begin
          if (is_alu_op(r_opcode)) begin
            r_state <= S_WB;
            r_regwe <= 1'b1;
          end else if ((r_opcode == OP_LD) || (r_opcode == OP_ST)) begin
            r_state <= S_MEM;
            r_dldm  <= 1'b1;
            r_memre <= (r_opcode == OP_LD);
            r_memwe <= (r_opcode == OP_ST);
          end else begin
            r_retired <= r_retired + 1'b1;
            r_state   <= run ? S_FETCH : S_IDLE;
            r_irwe    <= run;
            r_pcwe    <= run;
          end
        end

        S_MEM: begin
          if (mem_ready) begin
            if (r_opcode == OP_ST) begin
              r_retired <= r_retired + 1'b1;
              r_state   <= run ? S_FETCH : S_IDLE;
              r_irwe    <= run;
              r_pcwe    <= run;
            end else begin
              r_state <= S_WB;
              r_regwe <= 1'b1;
              r_dldm  <= 1'b1;
            end
          end else if (w_expired) begin
            r_error <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_dldm  <= 1'b1;
            r_memre <= (r_opcode == OP_LD);
            r_memwe <= (r_opcode == OP_ST);
          end
        end

        S_WB: begin
          r_retired <= r_retired + 1'b1;
          r_state   <= run ? S_FETCH : S_IDLE;
          r_irwe    <= run;
          r_pcwe    <= run;
        end

        S_HALT: begin
          if (run && !r_run_d && !r_error) begin
            r_state <= S_FETCH;
            r_irwe  <= 1'b1;
            r_pcwe  <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign IRWE       = r_irwe;
  assign PCWE       = r_pcwe;
  assign PCSrc      = r_pcsrc;
  assign JMP        = r_jmp;
  assign RegC       = r_regc;
  assign SBSC       = r_sbsc;
  assign RegWE      = r_regwe;
  assign MemWE      = r_memwe;
  assign MemRE      = r_memre;
  assign DLDM       = r_dldm;
  assign ALUcontrol = r_alu;
  assign state      = r_state;
  assign error      = r_error;
  assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;
  localparam logic [4:0] OP_JMP = 5'b01010, OP_LD = 5'b01111, OP_ST = 5'b10000,
                         OP_HLT = 5'b11111, OP_BAD = 5'b11010;

  logic        clk = 1'b0;
  logic        rst_n, run, mem_ready;
  logic [18:0] instr;
  logic [3:0]  flag;

  logic        IRWE, PCWE, PCSrc, JMP, RegC, SBSC, RegWE, MemWE, MemRE, DLDM, error;
  logic [4:0]  ALUcontrol;
  logic [2:0]  state;
  logic [15:0] retired;

  logic        IRWE_s, PCWE_s, PCSrc_s, JMP_s, RegC_s, SBSC_s, RegWE_s, MemWE_s, MemRE_s, DLDM_s, error_s;
  logic [4:0]  ALUcontrol_s;
  logic [2:0]  state_s;
  logic [3:0]  retired_s;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .flag(flag), .mem_ready(mem_ready),
    .IRWE(IRWE), .PCWE(PCWE), .PCSrc(PCSrc), .JMP(JMP), .RegC(RegC), .SBSC(SBSC),
    .RegWE(RegWE), .MemWE(MemWE), .MemRE(MemRE), .DLDM(DLDM), .ALUcontrol(ALUcontrol),
    .state(state), .error(error), .retired(retired)
  );

  multicycle_ctrl #(.RETIRE_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .flag(flag), .mem_ready(mem_ready),
    .IRWE(IRWE_s), .PCWE(PCWE_s), .PCSrc(PCSrc_s), .JMP(JMP_s), .RegC(RegC_s), .SBSC(SBSC_s),
    .RegWE(RegWE_s), .MemWE(MemWE_s), .MemRE(MemRE_s), .DLDM(DLDM_s), .ALUcontrol(ALUcontrol_s),
    .state(state_s), .error(error_s), .retired(retired_s)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_retired = 0;

  int st_cycles, st_irwe_fetch, st_decode_we, st_exec_pcwe, st_exec_pcsrc, st_exec_jmp;
  int st_exec_alu, st_exec_sbsc, st_exec_regc, st_exec_dldm, st_regwe, st_memre, st_memwe;
  int st_wb_dldm, st_timeout, st_end_state;

  typedef struct {
    logic [4:0] op;
    logic [3:0] fl;
    int         w;
    int         cycles;
    logic [4:0] alu;
    bit         pcwe;
    bit         jmp;
    bit         sbsc;
    bit         regc;
    bit         dldm;
    int         regwe;
    int         memre;
    int         memwe;
    bit         wb_dldm;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint all_outputs();
    return {IRWE, PCWE, PCSrc, JMP, RegC, SBSC, RegWE, MemWE, MemRE, DLDM,
            ALUcontrol, state, error, retired, retired_s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Releases reset with run high and checks the two-cycle synchronizer hold-off
  task automatic release_reset();
    rst_n = 1'b1;
    run   = 1'b1;
    step();
    step();
    check("sync_hold_idle", state, S_IDLE);
    step();
    check("sync_exit_fetch", state, S_FETCH);
  endtask

  task automatic exec_one(input logic [4:0] op, input logic [3:0] fl, input int w, input bit drop_run);
    int memcyc;
    bit done;
    instr = {op, 14'h0A5C};
    flag = fl;
    mem_ready = 1'b0;
    st_cycles = 0; st_irwe_fetch = 0; st_decode_we = 0; st_exec_pcwe = 0; st_exec_pcsrc = 0;
    st_exec_jmp = 0; st_exec_alu = 0; st_exec_sbsc = 0; st_exec_regc = 0; st_exec_dldm = 0;
    st_regwe = 0; st_memre = 0; st_memwe = 0; st_wb_dldm = 0; st_timeout = 0;
    memcyc = 0;
    done = 1'b0;
    while (!done) begin
      st_cycles++;
      case (state)
        S_FETCH:  st_irwe_fetch = IRWE;
        S_DECODE: st_decode_we += int'(IRWE | PCWE | RegWE | MemWE);
        S_EXEC: begin
          st_exec_pcwe = PCWE; st_exec_pcsrc = PCSrc; st_exec_jmp = JMP;
          st_exec_alu = ALUcontrol; st_exec_sbsc = SBSC; st_exec_regc = RegC; st_exec_dldm = DLDM;
          if (drop_run) run = 1'b0;
        end
        S_MEM: begin
          memcyc++;
          mem_ready = (memcyc > w);
        end
        S_WB:     st_wb_dldm = DLDM;
        default: ;
      endcase
      st_regwe += int'(RegWE);
      st_memre += int'(MemRE);
      st_memwe += int'(MemWE);
      step();
      mem_ready = 1'b0;
      if (state inside {S_FETCH, S_IDLE, S_HALT}) begin
        done = 1'b1;
      end else if (st_cycles >= 64) begin
        done = 1'b1;
        st_timeout = 1;
      end
    end
    st_end_state = state;
  endtask

  initial begin
    vecs[0]  = '{5'b00000, 4'h0, 0, 4, 5'b00000, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[1]  = '{5'b00100, 4'h0, 0, 4, 5'b00100, 0, 0, 1, 1, 0, 1, 0, 0, 0};
    vecs[2]  = '{5'b01001, 4'h8, 0, 4, 5'b01001, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[3]  = '{5'b01011, 4'h8, 0, 3, 5'b01011, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{5'b01011, 4'h0, 0, 3, 5'b01011, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{5'b01100, 4'h8, 0, 3, 5'b01011, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{5'b01100, 4'h0, 0, 3, 5'b01011, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{5'b01010, 4'h0, 0, 3, 5'b01010, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{5'b01111, 4'h0, 3, 8, 5'b01111, 0, 0, 0, 0, 1, 1, 4, 0, 1};
    vecs[9]  = '{5'b01111, 4'h0, 0, 5, 5'b01111, 0, 0, 0, 0, 1, 1, 1, 0, 1};
    vecs[10] = '{5'b10000, 4'h0, 2, 6, 5'b10000, 0, 0, 1, 0, 1, 0, 0, 3, 0};
    vecs[11] = '{5'b00101, 4'h7, 0, 4, 5'b00101, 0, 0, 1, 1, 0, 1, 0, 0, 0};

    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; instr = '0; flag = '0;
    step(); step(); step();
    check("reset_outputs", all_outputs(), 0);
    release_reset();

    for (int i = 0; i < 12; i++) begin
      exec_one(vecs[i].op, vecs[i].fl, vecs[i].w, 1'b0);
      exp_retired++;
      check($sformatf("v%0d_bound", i), st_timeout, 0);
      check($sformatf("v%0d_cycles", i), st_cycles, vecs[i].cycles);
      check($sformatf("v%0d_irwe_fetch", i), st_irwe_fetch, 1);
      check($sformatf("v%0d_decode_we", i), st_decode_we, 0);
      check($sformatf("v%0d_alu", i), st_exec_alu, vecs[i].alu);
      check($sformatf("v%0d_pcwe", i), st_exec_pcwe, vecs[i].pcwe);
      check($sformatf("v%0d_pcsrc", i), st_exec_pcsrc, vecs[i].pcwe);
      check($sformatf("v%0d_jmp", i), st_exec_jmp, vecs[i].jmp);
      check($sformatf("v%0d_sbsc", i), st_exec_sbsc, vecs[i].sbsc);
      check($sformatf("v%0d_regc", i), st_exec_regc, vecs[i].regc);
      check($sformatf("v%0d_exec_dldm", i), st_exec_dldm, vecs[i].dldm);
      check($sformatf("v%0d_regwe", i), st_regwe, vecs[i].regwe);
      check($sformatf("v%0d_memre", i), st_memre, vecs[i].memre);
      check($sformatf("v%0d_memwe", i), st_memwe, vecs[i].memwe);
      check($sformatf("v%0d_wb_dldm", i), st_wb_dldm, vecs[i].wb_dldm);
      check($sformatf("v%0d_end_state", i), st_end_state, S_FETCH);
      check($sformatf("v%0d_retired", i), retired, exp_retired);
      check($sformatf("v%0d_error", i), error, 0);
    end

    // run dropped while JMP is in EXEC: the jump still completes, then IDLE
    exec_one(OP_JMP, 4'h0, 0, 1'b1);
    exp_retired++;
    check("jmpdrop_cycles", st_cycles, 3);
    check("jmpdrop_pcwe", st_exec_pcwe, 1);
    check("jmpdrop_state", st_end_state, S_IDLE);
    check("jmpdrop_retired", retired, exp_retired);
    run = 1'b1;
    step();
    check("idle_restart", state, S_FETCH);

    while (exp_retired < 16) begin
      exec_one(OP_JMP, 4'h0, 0, 1'b0);
      exp_retired++;
    end
    check("wrap_small_retired", retired_s, 0);
    check("wrap_wide_retired", retired, 16);

    exec_one(OP_HLT, 4'h0, 0, 1'b0);
    exp_retired++;
    check("hlt_cycles", st_cycles, 2);
    check("hlt_state", st_end_state, S_HALT);
    check("hlt_error", error, 0);
    check("hlt_retired", retired, exp_retired);
    run = 1'b0;
    step();
    check("hlt_wait", state, S_HALT);
    run = 1'b1;
    step();
    check("hlt_run_edge", state, S_FETCH);

    exec_one(OP_BAD, 4'h0, 0, 1'b0);
    check("bad_state", st_end_state, S_HALT);
    check("bad_error", error, 1);
    check("bad_retired", retired, exp_retired);
    run = 1'b0; step(); step();
    run = 1'b1; step(); step(); step();
    check("bad_no_restart", state, S_HALT);

    #2 rst_n = 1'b0;
    #1 check("async_reset_halt", all_outputs(), 0);
    exp_retired = 0;
    step();
    release_reset();

    exec_one(OP_ST, 4'h0, 1000, 1'b0);
    check("st_to_cycles", st_cycles, 18);
    check("st_to_memwe", st_memwe, 15);
    check("st_to_state", st_end_state, S_HALT);
    check("st_to_error", error, 1);
    check("st_to_memwe_off", MemWE, 0);
    check("st_to_retired", retired, exp_retired);
    run = 1'b0; step();
    run = 1'b1; step(); step();
    check("st_to_no_restart", state, S_HALT);

    #2 rst_n = 1'b0;
    #1;
    step();
    release_reset();
    instr = {OP_LD, 14'h0};
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("mem_before_reset_state", state, S_MEM);
    check("mem_before_reset_memre", MemRE, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_mem", all_outputs(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
